fib_stack_ctrl: RTL and testbench
=================================

Name: fib_stack_ctrl

Overview:
- Sequencing controller for the 64-bit LIFO stack in the stack-based customized Fibonacci engine.
- Evaluates F(n) = F(n-1) + F(n-2) with user base values F(0)=c0 and F(1)=c1. The recursion is expanded on the external stack:
  - push n;
  - repeat: pop x; if x<2, accumulate the base value; otherwise push x-1, then push x-2;
  - stop when the stack is empty.
- Sits between the host start/result interface and the stack's push/pop/top/d_in/d_out/is_empty port set.

Parameters:
- N_W, 5: width of n_in.
- MAX_N, 30: largest accepted n. Peak stack occupancy is n+1 entries, which must fit the stack depth.
- D_W, 64: data and result width; matches the stack word.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle request; honoured only in IDLE.
- n_in  in  N_W  Fibonacci index; sampled with start.
- c0  in  D_W  base value F(0); sampled with start.
- c1  in  D_W  base value F(1); sampled with start.
- busy  out  1  high from the cycle after an accepted start until done.
- done  out  1  one-cycle pulse when result is valid.
- result  out  D_W  F(n) modulo 2^D_W; held until the next accepted start.
- ovf  out  1  sticky; set if any accumulation carried out of D_W; cleared on accepted start.
- err  out  1  one-cycle pulse when a start is rejected.
- stk_push  out  1  stack push strobe.
- stk_pop  out  1  stack pop strobe.
- stk_top  out  1  tied 0; unused.
- stk_d_in  out  D_W  word to push.
- stk_d_out  in  D_W  popped word; valid the cycle after stk_pop.
- stk_is_empty  in  1  stack-empty flag.

Behaviour:
- Reset values:
  - state=IDLE.
  - busy, done, err, ovf, stk_push, stk_pop, stk_top = 0.
  - result, stk_d_in, accumulator = 0.
- Reset has priority over all other logic. The stack shares rst, so reset mid-operation empties the stack and returns the controller to IDLE without a done pulse.
- Only one strobe is asserted in any cycle: stk_push or stk_pop, never both.
- Operand registers n_r, c0_r, c1_r are latched on an accepted start. Inputs may then change freely.
- States:
  - IDLE:
    - If start and n_in>MAX_N, or start while stk_is_empty=0: pulse err, stay in IDLE, no stack access.
    - If start and valid: latch operands, clear acc and ovf, go to PUSH_N.
  - PUSH_N: stk_push=1, stk_d_in=n_r, then go to POP.
  - POP: stk_pop=1, then go to EVAL.
  - EVAL: x = stk_d_out[N_W-1:0]. Upper bits of stk_d_out are ignored.
    - If x<2: acc += (x==0 ? c0_r : c1_r), set ovf on carry-out. Then go to FIN if stk_is_empty, else go to POP. stk_is_empty already reflects the pop.
    - If x>=2: hold x in a register and go to PUSH1.
  - PUSH1: push x-1, then go to PUSH2.
  - PUSH2: push x-2, then go to POP.
  - FIN: result<=acc, done=1 for this cycle, busy deasserts, go to IDLE.
- Latency:
  - With L = number of leaves = fib(n+1) (1,1,2,3,5,8,…), busy lasts exactly 6L-3 cycles (PUSH_N through the final EVAL).
  - done is asserted in the following cycle.
  - Example: n=0 gives 3 busy cycles, then done.
- start while busy is ignored: no err, operands unchanged.
- A new start is accepted in the cycle after done (IDLE).
- Arithmetic: the accumulator wraps modulo 2^D_W; ovf records that a wrap occurred.

Decomposition:
- Package fib_ctrl_pkg holds:
  - state enumeration: IDLE, PUSH_N, POP, EVAL, PUSH1, PUSH2, FIN;
  - default N_W, D_W, MAX_N;
  - stack depth constant 512, with a MAX_N<512 compile-time check.
- Single flat FSM plus datapath; no sub-module.
- The integration wrapper fib_stack_top instantiates the stack and this block. It is out of scope here.

Test Plan:
- n=0, c0=3, c1=5 -> busy for 3 cycles, done, result=3, ovf=0, exactly one push and one pop.
- n=5, c0=0, c1=1 -> result=5; L=8; busy for 45 cycles; stack empty at done; peak occupancy <=6.
- n=4, c0=2, c1=3 -> result=13. An immediate second start with n=1 -> result=3.
- n=31 (>MAX_N) -> err pulse, no stk_push, busy stays 0. Start while stk_is_empty=0 -> err pulse.
- n=3, c0=0, c1=2^63 -> result=0, ovf=1. A following start with n=1 clears ovf.
- Assert rst during PUSH2 of an n=6 run -> all outputs at reset values, no done pulse. A following n=2, c0=1, c1=1 run -> result=2.

Source files
------------

// File: rtl/fib_ctrl_pkg.sv
// Shared types and default sizing for the stack-based Fibonacci controller.
package fib_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE,
    PUSH_N,
    POP,
    EVAL,
    PUSH1,
    PUSH2,
    FIN
  } state_t;

  localparam int N_W_DEF     = 5;
  localparam int D_W_DEF     = 64;
  localparam int MAX_N_DEF   = 30;
  localparam int STACK_DEPTH = 512;

endpackage

// File: rtl/fib_stack_ctrl_if.sv
// Push/pop port set between the Fibonacci controller and the 64-bit LIFO stack.
interface fib_stack_ctrl_if #(
  parameter int D_W = 64
);
  logic           stk_push;
  logic           stk_pop;
  logic           stk_top;
  logic [D_W-1:0] stk_d_in;
  logic [D_W-1:0] stk_d_out;
  logic           stk_is_empty;

  modport master (
    output stk_push, stk_pop, stk_top, stk_d_in,
    input  stk_d_out, stk_is_empty
  );

  modport slave (
    input  stk_push, stk_pop, stk_top, stk_d_in,
    output stk_d_out, stk_is_empty
  );
endinterface

// File: rtl/fib_stack_ctrl.sv
// Expands F(n) = F(n-1) + F(n-2) on an external stack and sums the base-value leaves.
module fib_stack_ctrl
  import fib_ctrl_pkg::*;
#(
  parameter int N_W   = N_W_DEF,
  parameter int MAX_N = MAX_N_DEF,
  parameter int D_W   = D_W_DEF
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [N_W-1:0] n_in,
  input  logic [D_W-1:0] c0,
  input  logic [D_W-1:0] c1,
  output logic           busy,
  output logic           done,
  output logic [D_W-1:0] result,
  output logic           ovf,
  output logic           err,
  fib_stack_ctrl_if.master stk
);

  // Peak occupancy is n+1 words, and n must be representable in N_W bits.
  if (MAX_N >= STACK_DEPTH) begin : g_depth_chk
    $error("MAX_N must be below the stack depth");
  end
  if (MAX_N >= (1 << N_W)) begin : g_width_chk
    $error("MAX_N must fit in N_W bits");
  end

  localparam logic [N_W-1:0] MAX_N_V = N_W'(MAX_N);

  state_t         state;
  logic [D_W-1:0] c0_r;
  logic [D_W-1:0] c1_r;
  logic [D_W-1:0] acc;
  logic [N_W-1:0] x_r;

  logic [N_W-1:0] x;
  logic           is_leaf;
  logic [D_W-1:0] base;
  logic [D_W:0]   sum;
  logic           unused_hi;

  // Only the low N_W bits of a popped word carry an index.
  assign x         = stk.stk_d_out[N_W-1:0];
  assign unused_hi = ^stk.stk_d_out[D_W-1:N_W];
  assign is_leaf   = (x < N_W'(2));
  assign base      = (x == '0) ? c0_r : c1_r;
  assign sum       = {1'b0, acc} + {1'b0, base};
  assign stk.stk_top = 1'b0;

  // NOTE: outputs are registered, so each is set on the transition into the
  // state where it must be visible; all state uses non-blocking assignment.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      busy         <= 1'b0;
      done         <= 1'b0;
      err          <= 1'b0;
      ovf          <= 1'b0;
      result       <= '0;
      acc          <= '0;
      c0_r         <= '0;
      c1_r         <= '0;
      x_r          <= '0;
      stk.stk_push <= 1'b0;
      stk.stk_pop  <= 1'b0;
      stk.stk_d_in <= '0;
    end else begin
      done         <= 1'b0;
      err          <= 1'b0;
      stk.stk_push <= 1'b0;
      stk.stk_pop  <= 1'b0;

      unique case (state)
        IDLE: begin
          if (start) begin
            if ((n_in > MAX_N_V) || !stk.stk_is_empty) begin
              err <= 1'b1;
            end else begin
              c0_r         <= c0;
              c1_r         <= c1;
              acc          <= '0;
              ovf          <= 1'b0;
              busy         <= 1'b1;
              stk.stk_push <= 1'b1;
              stk.stk_d_in <= D_W'(n_in);
              state        <= PUSH_N;
            end
          end
        end

        PUSH_N: begin
          stk.stk_pop <= 1'b1;
          state       <= POP;
        end

        POP: state <= EVAL;

        EVAL: begin
          if (is_leaf) begin
            acc <= sum[D_W-1:0];
            ovf <= ovf | sum[D_W];
            // The empty flag already reflects the pop that produced x.
            if (stk.stk_is_empty) begin
              result <= sum[D_W-1:0];
              busy   <= 1'b0;
              done   <= 1'b1;
              state  <= FIN;
            end else begin
              stk.stk_pop <= 1'b1;
              state       <= POP;
            end
          end else begin
            x_r          <= x;
            stk.stk_push <= 1'b1;
            stk.stk_d_in <= D_W'(x - 1'b1);
            state        <= PUSH1;
          end
        end

        PUSH1: begin
          stk.stk_push <= 1'b1;
          stk.stk_d_in <= D_W'(x_r - N_W'(2));
          state        <= PUSH2;
        end

        PUSH2: begin
          stk.stk_pop <= 1'b1;
          state       <= POP;
        end

        FIN: state <= IDLE;

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fib_stack_ctrl.sv
// Self-checking bench for fib_stack_ctrl with a behavioural LIFO and leaf-count model.
module tb_fib_stack_ctrl;
  import fib_ctrl_pkg::*;

  localparam int NW = 5;
  localparam int DW = 64;
  localparam int MN = 30;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [NW-1:0] n_in;
  logic [DW-1:0] c0, c1;
  logic          busy, done, ovf, err;
  logic [DW-1:0] result;

  always #5 clk = ~clk;

  fib_stack_ctrl_if #(.D_W(DW)) stk_bus ();

  fib_stack_ctrl #(.N_W(NW), .MAX_N(MN), .D_W(DW)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .n_in   (n_in),
    .c0     (c0),
    .c1     (c1),
    .busy   (busy),
    .done   (done),
    .result (result),
    .ovf    (ovf),
    .err    (err),
    .stk    (stk_bus)
  );

  // Behavioural stack: d_out valid the cycle after a pop; shares rst.
  logic [DW-1:0] mem [STACK_DEPTH];
  int            sp;
  logic          hold_nonempty;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      sp                <= 0;
      stk_bus.stk_d_out <= '0;
    end else if (stk_bus.stk_push && sp < STACK_DEPTH) begin
      mem[sp] <= stk_bus.stk_d_in;
      sp      <= sp + 1;
    end else if (stk_bus.stk_pop && sp > 0) begin
      stk_bus.stk_d_out <= mem[sp-1];
      sp                <= sp - 1;
    end
  end

  assign stk_bus.stk_is_empty = (sp == 0) && !hold_nonempty;

  // Activity monitor, sampled just after the falling edge.
  int n_push, n_pop, n_both, n_done, n_err, n_under, n_top, peak;
  initial begin
    {n_push, n_pop, n_both, n_done, n_err, n_under, n_top, peak} = '0;
  end
  always begin
    @(negedge clk);
    #1;
    if (!rst) begin
      n_push  += int'(stk_bus.stk_push);
      n_pop   += int'(stk_bus.stk_pop);
      n_both  += int'(stk_bus.stk_push && stk_bus.stk_pop);
      n_done  += int'(done);
      n_err   += int'(err);
      n_top   += int'(stk_bus.stk_top);
      n_under += int'(stk_bus.stk_pop && sp == 0);
      if (sp > peak) peak = sp;
    end
  end

  int n_vec  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Leaf counts: a tree rooted at n has z leaves equal to 0 and o leaves equal to 1.
  function automatic void leaves(input int n, output longint z, output longint o);
    longint z0 = 1, o0 = 0, z1 = 0, o1 = 1, zt, ot;
    if (n == 0) begin z = z0; o = o0; return; end
    for (int k = 2; k <= n; k++) begin
      zt = z0 + z1; ot = o0 + o1;
      z0 = z1; o0 = o1; z1 = zt; o1 = ot;
    end
    z = z1; o = o1;
  endfunction

  function automatic void model(input int n, input logic [DW-1:0] a, input logic [DW-1:0] b,
                                output logic [DW-1:0] res, output logic o_ovf, output int bc);
    longint z, o;
    logic [127:0] exact;
    leaves(n, z, o);
    exact = 128'(z) * 128'(a) + 128'(o) * 128'(b);
    res   = exact[DW-1:0];
    o_ovf = |exact[127:DW];
    bc    = int'(6 * (z + o) - 3);
  endfunction

  task automatic run_op(input int n, input logic [DW-1:0] a, input logic [DW-1:0] b,
                        input bit poke_busy, output logic [DW-1:0] res, output logic o_ovf,
                        output int bc, output bit ok);
    start = 1'b1; n_in = NW'(n); c0 = a; c1 = b;
    @(negedge clk);
    start = 1'b0;
    n_in = NW'($urandom); c0 = {$urandom, $urandom}; c1 = {$urandom, $urandom};
    bc = 0; ok = 1'b0; res = '0; o_ovf = 1'b0;
    for (int i = 0; i < 20000; i++) begin
      if (done) begin
        ok = 1'b1; res = result; o_ovf = ovf;
        break;
      end
      if (busy) bc++;
      start = poke_busy && (bc == 5);
      if (start) n_in = NW'($urandom);
      @(negedge clk);
    end
    start = 1'b0;
    if (ok) @(negedge clk);
  endtask

  task automatic do_run(input string name, input int n, input logic [DW-1:0] a,
                        input logic [DW-1:0] b, input logic [DW-1:0] exp_res,
                        input bit exp_ovf, input int exp_bc, input bit poke_busy);
    logic [DW-1:0] res;
    logic          o;
    int            bc, p0, q0, e0;
    bit            ok;
    longint        z, one;
    leaves(n, z, one);
    p0 = n_push; q0 = n_pop; e0 = n_err; peak = 0;
    run_op(n, a, b, poke_busy, res, o, bc, ok);
    check({name, " done_seen"}, 128'(ok), 128'(1));
    check({name, " result"}, 128'(res), 128'(exp_res));
    check({name, " ovf"}, 128'(o), 128'(exp_ovf));
    check({name, " busy_cycles"}, 128'(bc), 128'(exp_bc));
    check({name, " pushes"}, 128'(n_push - p0), 128'(2 * (z + one) - 1));
    check({name, " pops"}, 128'(n_pop - q0), 128'(2 * (z + one) - 1));
    check({name, " peak_ok"}, 128'(peak <= n + 1), 128'(1));
    check({name, " empty_after"}, 128'(sp), 128'(0));
    check({name, " result_held"}, 128'(result), 128'(exp_res));
    check({name, " no_err"}, 128'(n_err - e0), 128'(0));
  endtask

  typedef struct {
    int            n;
    logic [DW-1:0] c0;
    logic [DW-1:0] c1;
    logic [DW-1:0] res;
    bit            ovf;
    int            bc;
  } vec_t;

  vec_t tbl[$];

  initial begin
    logic [DW-1:0] mres;
    logic          movf;
    int            mbc, e0, p0, d0;
    bit            found, prev_push;

    tbl.push_back('{0, 64'd3, 64'd5, 64'd3,  1'b0, 3});
    tbl.push_back('{5, 64'd0, 64'd1, 64'd5,  1'b0, 45});
    tbl.push_back('{4, 64'd2, 64'd3, 64'd13, 1'b0, 27});
    tbl.push_back('{1, 64'd2, 64'd3, 64'd3,  1'b0, 3});
    tbl.push_back('{3, 64'd0, 64'h8000_0000_0000_0000, 64'd0, 1'b1, 15});
    tbl.push_back('{1, 64'd0, 64'd7, 64'd7,  1'b0, 3});
    tbl.push_back('{2, 64'd1, 64'd1, 64'd2,  1'b0, 9});

    rst = 1'b1; start = 1'b0; n_in = '0; c0 = '0; c1 = '0; hold_nonempty = 1'b0;
    @(negedge clk);
    check("reset busy", 128'(busy), 128'(0));
    check("reset done", 128'(done), 128'(0));
    check("reset err", 128'(err), 128'(0));
    check("reset ovf", 128'(ovf), 128'(0));
    check("reset result", 128'(result), 128'(0));
    check("reset strobes", 128'({stk_bus.stk_push, stk_bus.stk_pop, stk_bus.stk_top}), 128'(0));
    check("reset d_in", 128'(stk_bus.stk_d_in), 128'(0));
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Back-to-back table runs: each start lands in the IDLE cycle right after done.
    for (int i = 0; i < tbl.size(); i++)
      do_run($sformatf("tbl%0d", i), tbl[i].n, tbl[i].c0, tbl[i].c1,
             tbl[i].res, tbl[i].ovf, tbl[i].bc, 1'b0);

    // Randomised runs against the model; odd runs also fire start mid-operation.
    for (int i = 0; i < 12; i++) begin
      int            n;
      logic [DW-1:0] a, b;
      n = int'($urandom_range(0, 12));
      a = {$urandom, $urandom};
      b = ($urandom_range(0, 1) == 1) ? 64'($urandom_range(0, 1000)) : {$urandom, $urandom};
      model(n, a, b, mres, movf, mbc);
      do_run($sformatf("rnd%0d", i), n, a, b, mres, movf, mbc, (i % 2) == 1);
    end

    // Rejected starts: index above MAX_N, then stack not empty.
    e0 = n_err; p0 = n_push;
    start = 1'b1; n_in = NW'(31);
    @(negedge clk);
    start = 1'b0;
    check("err_range pulse", 128'(err), 128'(1));
    check("err_range busy", 128'(busy), 128'(0));
    @(negedge clk);
    check("err_range one_cycle", 128'(err), 128'(0));
    hold_nonempty = 1'b1;
    start = 1'b1; n_in = NW'(2);
    @(negedge clk);
    start = 1'b0;
    check("err_nonempty pulse", 128'(err), 128'(1));
    @(negedge clk);
    hold_nonempty = 1'b0;
    check("err_nonempty busy", 128'(busy), 128'(0));
    @(negedge clk);
    check("err count", 128'(n_err - e0), 128'(2));
    check("err no_push", 128'(n_push - p0), 128'(0));

    // Reset during PUSH2 (second of two consecutive push cycles) of an n=6 run.
    start = 1'b1; n_in = NW'(6); c0 = 64'd1; c1 = 64'd1;
    @(negedge clk);
    start = 1'b0;
    found = 1'b0; prev_push = 1'b0;
    for (int i = 0; i < 500; i++) begin
      if (stk_bus.stk_push && prev_push) begin found = 1'b1; break; end
      prev_push = stk_bus.stk_push;
      @(negedge clk);
    end
    check("mid_rst push2_found", 128'(found), 128'(1));
    d0 = n_done;
    rst = 1'b1;
    #1;
    check("mid_rst outputs", 128'({busy, done, err, ovf, stk_bus.stk_push, stk_bus.stk_pop}), 128'(0));
    check("mid_rst result", 128'(result), 128'(0));
    check("mid_rst stack", 128'(sp), 128'(0));
    @(negedge clk);
    rst = 1'b0;
    repeat (10) @(negedge clk);
    check("mid_rst no_done", 128'(n_done - d0), 128'(0));
    do_run("after_rst", 2, 64'd1, 64'd1, 64'd2, 1'b0, 9, 1'b0);

    check("never both strobes", 128'(n_both), 128'(0));
    check("no underflow", 128'(n_under), 128'(0));
    check("top tied low", 128'(n_top), 128'(0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
